// File: rtl/mem_access.sv
// LC-3b memory stage: drives data-memory transactions and registers the MEM/WB result.
// Define MEM_ACCESS_INDIRECT_EN for two-phase LDI/STI through a latched pointer.
module mem_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [3:0]  opcode,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        load_regfile_in,
    input  logic        load_cc_in,
    input  logic [2:0]  dr_in,
    input  logic [15:0] address,
    input  logic [15:0] result,
    input  logic [15:0] store_data,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        wb_load_regfile,
    output logic        wb_load_cc,
    output logic [2:0]  wb_dr,
    output logic [15:0] wb_data
);

    localparam logic [3:0] OpLdb = 4'h2;
    localparam logic [3:0] OpStb = 4'h3;
`ifdef MEM_ACCESS_INDIRECT_EN
    localparam logic [3:0] OpLdi = 4'hA;
    localparam logic [3:0] OpSti = 4'hB;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StAccess
`ifdef MEM_ACCESS_INDIRECT_EN
        , StIndirect
`endif
    } state_e;

    state_e      state_q, state_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic        wb_valid_q, wb_valid_d, wb_lr_q, wb_lr_d, wb_cc_q, wb_cc_d;
    logic [2:0]  wb_dr_q, wb_dr_d;
    logic [15:0] wb_data_q, wb_data_d;
`ifdef MEM_ACCESS_INDIRECT_EN
    logic [14:0] ptr_q, ptr_d;
    logic        is_ind;
`endif

    logic        mem_op, is_byte, first_rd, capture;
    logic [15:0] first_addr, first_wdata, load_data, wb_src;
    logic [1:0]  first_be;
    logic [7:0]  lane;

    always_comb begin
        mem_op   = valid_in & (mem_read | mem_write);
        is_byte  = (opcode == OpLdb) | (opcode == OpStb);
`ifdef MEM_ACCESS_INDIRECT_EN
        is_ind   = (opcode == OpLdi) | (opcode == OpSti);
        // STI also starts with a read: the first access fetches the pointer.
        first_rd = mem_read | is_ind;
`else
        first_rd = mem_read;
`endif
        first_addr  = is_byte ? address : {address[15:1], 1'b0};
        first_be    = (is_byte & ~first_rd) ? (address[0] ? 2'b10 : 2'b01) : 2'b11;
        first_wdata = first_rd ? 16'h0000 :
                      (is_byte ? {store_data[7:0], store_data[7:0]} : store_data);
        lane        = address[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
        load_data   = (opcode == OpLdb) ? {{8{lane[7]}}, lane} : dmem_rdata;
        wb_src      = mem_read ? load_data : result;
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        wb_valid_d = 1'b0;
        wb_lr_d    = 1'b0;
        wb_cc_d    = 1'b0;
        wb_dr_d    = wb_dr_q;
        wb_data_d  = wb_data_q;
        capture    = 1'b0;
`ifdef MEM_ACCESS_INDIRECT_EN
        ptr_d      = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    state_d = StAccess;
                    rd_d    = first_rd;
                    wr_d    = ~first_rd;
                    addr_d  = first_addr;
                    be_d    = first_be;
                    wdata_d = first_wdata;
                end else begin
                    capture = 1'b1;
                end
            end
            StAccess: begin
                if (dmem_resp) begin
`ifdef MEM_ACCESS_INDIRECT_EN
                    if (is_ind) begin
                        state_d = StIndirect;
                        ptr_d   = dmem_rdata[15:1];
                        rd_d    = (opcode == OpLdi);
                        wr_d    = (opcode == OpSti);
                        be_d    = 2'b11;
                        wdata_d = (opcode == OpSti) ? store_data : 16'h0000;
                    end else begin
                        capture = 1'b1;
                    end
`else
                    capture = 1'b1;
`endif
                end
            end
`ifdef MEM_ACCESS_INDIRECT_EN
            StIndirect: begin
                if (dmem_resp) begin
                    capture = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Capture covers both pass-through instructions and completing memory ops.
        if (capture) begin
            state_d    = StIdle;
            rd_d       = 1'b0;
            wr_d       = 1'b0;
            addr_d     = 16'h0000;
            be_d       = 2'b00;
            wdata_d    = 16'h0000;
            wb_valid_d = valid_in;
            wb_lr_d    = valid_in & load_regfile_in;
            wb_cc_d    = valid_in & load_cc_in;
            wb_dr_d    = dr_in;
            wb_data_d  = wb_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 16'h0000;
            be_q       <= 2'b00;
            wdata_q    <= 16'h0000;
            wb_valid_q <= 1'b0;
            wb_lr_q    <= 1'b0;
            wb_cc_q    <= 1'b0;
            wb_dr_q    <= 3'd0;
            wb_data_q  <= 16'h0000;
`ifdef MEM_ACCESS_INDIRECT_EN
            ptr_q      <= 15'h0000;
`endif
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_lr_q    <= wb_lr_d;
            wb_cc_q    <= wb_cc_d;
            wb_dr_q    <= wb_dr_d;
            wb_data_q  <= wb_data_d;
`ifdef MEM_ACCESS_INDIRECT_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

`ifdef MEM_ACCESS_INDIRECT_EN
    assign dmem_address = (state_q == StIndirect) ? {ptr_q, 1'b0} : addr_q;
`else
    assign dmem_address = addr_q;
`endif
    assign dmem_read        = rd_q;
    assign dmem_write       = wr_q;
    assign dmem_byte_enable = be_q;
    assign dmem_wdata       = wdata_q;
    assign mem_stall        = ~capture;
    assign wb_valid         = wb_valid_q;
    assign wb_load_regfile  = wb_lr_q;
    assign wb_load_cc       = wb_cc_q;
    assign wb_dr            = wb_dr_q;
    assign wb_data          = wb_data_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: a per-instruction reference model derives expected
// memory accesses and MEM/WB contents; the bench acts as the data memory.
module tb_mem_access;

    localparam logic [3:0] OpAdd = 4'h1, OpLdb = 4'h2, OpStb = 4'h3, OpLdr = 4'h6;
    localparam logic [3:0] OpStr = 4'h7, OpLdi = 4'hA, OpSti = 4'hB, OpLea = 4'hE;
`ifdef MEM_ACCESS_INDIRECT_EN
    localparam bit IndEn = 1'b1;
`else
    localparam bit IndEn = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        valid_in = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic        load_regfile_in = 1'b0, load_cc_in = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic [2:0]  dr_in = 3'd0;
    logic [15:0] address = 16'h0, result = 16'h0, store_data = 16'h0, dmem_rdata = 16'h0;
    logic        dmem_resp = 1'b0;
    logic [15:0] dmem_address, dmem_wdata, wb_data;
    logic        dmem_read, dmem_write, mem_stall, wb_valid, wb_load_regfile, wb_load_cc;
    logic [1:0]  dmem_byte_enable;
    logic [2:0]  wb_dr;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .opcode           (opcode),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .load_regfile_in  (load_regfile_in),
        .load_cc_in       (load_cc_in),
        .dr_in            (dr_in),
        .address          (address),
        .result           (result),
        .store_data       (store_data),
        .dmem_address     (dmem_address),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .mem_stall        (mem_stall),
        .wb_valid         (wb_valid),
        .wb_load_regfile  (wb_load_regfile),
        .wb_load_cc       (wb_load_cc),
        .wb_dr            (wb_dr),
        .wb_data          (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sext8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

    // Present one instruction, play the memory with the given latencies and read data,
    // and compare every cycle against what the ISA rules demand.
    task automatic run_instr(input logic [3:0] op, input logic v, input logic [15:0] addr,
                             input logic [15:0] res, input logic [15:0] sd,
                             input logic [2:0] dr, input int lat1, input int lat2,
                             input logic [15:0] rd1, input logic [15:0] rd2);
        logic        ld, st, byt, ind, lr, cc, memop, e_rd, e_wr;
        logic [15:0] e_addr, e_wd, e_data;
        logic [1:0]  e_be;
        int          n_acc, lat;
        ld  = (op == OpLdr) || (op == OpLdb) || (op == OpLdi);
        st  = (op == OpStr) || (op == OpStb) || (op == OpSti);
        byt = (op == OpLdb) || (op == OpStb);
        ind = IndEn && ((op == OpLdi) || (op == OpSti));
        lr  = !st && (op != 4'h0) && (op != 4'hC) && (op != 4'h4);
        cc  = lr && (op != OpLea);
        memop = v && (ld || st);

        opcode = op; valid_in = v; address = addr; result = res; store_data = sd;
        dr_in = dr; mem_read = ld; mem_write = st; load_regfile_in = lr; load_cc_in = cc;
        dmem_resp = 1'b0;

        if (!memop) begin
            // Occasional stray response while idle must be ignored.
            dmem_resp  = ($urandom_range(0, 3) == 0);
            dmem_rdata = 16'($urandom);
            #4;
            check("stall_nonmem", 16'(mem_stall), 16'd0);
            check("rd_nonmem", 16'(dmem_read), 16'd0);
            check("wr_nonmem", 16'(dmem_write), 16'd0);
            @(posedge clk); #1;
            dmem_resp = 1'b0;
            check("wb_valid_nm", 16'(wb_valid), 16'(v));
            check("wb_lr_nm", 16'(wb_load_regfile), 16'(v && lr));
            check("wb_cc_nm", 16'(wb_load_cc), 16'(v && cc));
            if (v) begin
                check("wb_dr_nm", 16'(wb_dr), 16'(dr));
                check("wb_data_nm", wb_data, res);
            end
            return;
        end

        #4;
        check("stall_idle", 16'(mem_stall), 16'd1);
        @(posedge clk); #1;
        n_acc = ind ? 2 : 1;
        for (int a = 0; a < n_acc; a++) begin
            if (a == 0) begin
                e_addr = byt ? addr : (addr & 16'hFFFE);
                e_rd   = ld || ind;
                e_be   = (!e_rd && byt) ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
                e_wd   = byt ? {sd[7:0], sd[7:0]} : sd;
                lat    = lat1;
            end else begin
                e_addr = rd1 & 16'hFFFE;
                e_rd   = (op == OpLdi);
                e_be   = 2'b11;
                e_wd   = sd;
                lat    = lat2;
            end
            e_wr = !e_rd;
            for (int k = 1; k <= lat; k++) begin
                check("dmem_read", 16'(dmem_read), 16'(e_rd));
                check("dmem_write", 16'(dmem_write), 16'(e_wr));
                check("dmem_address", dmem_address, e_addr);
                if (!(e_rd && byt)) check("dmem_be", 16'(dmem_byte_enable), 16'(e_be));
                if (e_wr) check("dmem_wdata", dmem_wdata, e_wd);
                check("wb_bubble", 16'(wb_valid), 16'd0);
                if (k == lat) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = (a == 0) ? rd1 : rd2;
                end
                #4;
                check("stall_busy", 16'(mem_stall), 16'(!(k == lat && a == n_acc - 1)));
                @(posedge clk); #1;
                dmem_resp  = 1'b0;
                dmem_rdata = 16'($urandom);
            end
        end

        if (ld) begin
            if (op == OpLdb) e_data = sext8(addr[0] ? rd1[15:8] : rd1[7:0]);
            else             e_data = ind ? rd2 : rd1;
        end else begin
            e_data = res;
        end
        check("wb_valid", 16'(wb_valid), 16'd1);
        check("wb_lr", 16'(wb_load_regfile), 16'(lr));
        check("wb_cc", 16'(wb_load_cc), 16'(cc));
        check("wb_dr", 16'(wb_dr), 16'(dr));
        check("wb_data", wb_data, e_data);
        check("rd_after", 16'(dmem_read), 16'd0);
        check("wr_after", 16'(dmem_write), 16'd0);
    endtask

    initial begin
        logic [3:0] op;
        #2;
        check("rst_read", 16'(dmem_read), 16'd0);
        check("rst_write", 16'(dmem_write), 16'd0);
        check("rst_addr", dmem_address, 16'd0);
        check("rst_be", 16'(dmem_byte_enable), 16'd0);
        check("rst_wdata", dmem_wdata, 16'd0);
        check("rst_wb_valid", 16'(wb_valid), 16'd0);
        check("rst_wb_lr", 16'(wb_load_regfile), 16'd0);
        check("rst_wb_cc", 16'(wb_load_cc), 16'd0);
        check("rst_wb_dr", 16'(wb_dr), 16'd0);
        check("rst_wb_data", wb_data, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(OpAdd, 1'b1, 16'h0000, 16'h1234, 16'h0000, 3'd3, 1, 1, 16'h0, 16'h0);
        run_instr(OpLdr, 1'b1, 16'h3001, 16'h1111, 16'h0000, 3'd5, 3, 1, 16'hBEEF, 16'h0);
        run_instr(OpLdb, 1'b1, 16'h4001, 16'h2222, 16'h0000, 3'd1, 1, 1, 16'h80FF, 16'h0);
        run_instr(OpLdb, 1'b1, 16'h4000, 16'h2222, 16'h0000, 3'd2, 2, 1, 16'h80FF, 16'h0);
        run_instr(OpStb, 1'b1, 16'h4000, 16'h3333, 16'hABCD, 3'd0, 1, 1, 16'h0, 16'h0);
        run_instr(OpStb, 1'b1, 16'h4001, 16'h3333, 16'hABCD, 3'd0, 2, 1, 16'h0, 16'h0);
        run_instr(OpSti, 1'b1, 16'h5000, 16'h4444, 16'h1357, 3'd0, 2, 2, 16'h6000, 16'h0);
        run_instr(OpLdi, 1'b1, 16'h5002, 16'h5555, 16'h0000, 3'd6, 1, 3, 16'h6001, 16'hC0DE);
        run_instr(OpLdr, 1'b0, 16'h7000, 16'h6666, 16'h0000, 3'd4, 1, 1, 16'h0, 16'h0);

        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            run_instr(op, ($urandom_range(0, 7) != 0), 16'($urandom), 16'($urandom),
                      16'($urandom), 3'($urandom), $urandom_range(1, 4),
                      $urandom_range(1, 4), 16'($urandom), 16'($urandom));
        end

        // Reset in the middle of an outstanding read abandons it.
        opcode = OpLdr; valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        load_regfile_in = 1'b1; load_cc_in = 1'b1; address = 16'h3002;
        @(posedge clk); #1;
        check("pre_rst_read", 16'(dmem_read), 16'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_read", 16'(dmem_read), 16'd0);
        check("mid_rst_addr", dmem_address, 16'd0);
        check("mid_rst_wb_valid", 16'(wb_valid), 16'd0);
        valid_in = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
        #4;
        check("idle_resp_stall", 16'(mem_stall), 16'd0);
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        check("idle_resp_read", 16'(dmem_read), 16'd0);
        check("idle_resp_write", 16'(dmem_write), 16'd0);
        check("idle_resp_wb_valid", 16'(wb_valid), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory stage of the LC-3b pipeline. It sits between the execute stage's output latch and writeback, and consumes execute's `address`, `result`, `cw`, `dr` and `valid`. It runs all data-memory transactions over a request/response port, including two-phase indirect LDI/STI and byte-lane LDB/STB. It stalls the upstream pipeline while a transaction is outstanding and registers the MEM/WB result.

## Interface
Parameters: none (widths fixed by `lc3b_types`).

- `clk` input 1: pipeline clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid_in` input 1: instruction in the EX/MEM latch is real.
- `opcode` input 4 (`lc3b_opcode`): instruction opcode.
- `mem_read` input 1: control-word read request.
- `mem_write` input 1: control-word write request.
- `load_regfile_in` input 1: control-word register write.
- `load_cc_in` input 1: control-word CC update.
- `dr_in` input 3: destination register.
- `address` input 16: effective address from execute.
- `result` input 16: ALU/LEA result from execute.
- `store_data` input 16: source register value for stores.
- `dmem_address` output 16: data-memory address.
- `dmem_read` output 1: read request; held until `dmem_resp`.
- `dmem_write` output 1: write request; held until `dmem_resp`.
- `dmem_byte_enable` output 2: write lane mask.
- `dmem_wdata` output 16: write data.
- `dmem_rdata` input 16: read data, valid with `dmem_resp`.
- `dmem_resp` input 1: one-cycle completion pulse.
- `mem_stall` output 1: combinational; upstream must hold the EX/MEM latch while high.
- `wb_valid` output 1, registered: MEM/WB valid.
- `wb_load_regfile` output 1, registered: MEM/WB register-write enable.
- `wb_load_cc` output 1, registered: MEM/WB CC-update enable.
- `wb_dr` output 3, registered: MEM/WB destination register.
- `wb_data` output 16, registered: MEM/WB write data.

## Operation
- A memory op is `valid_in & (mem_read | mem_write)`. It covers LDR, LDB, LDI, STR, STB and STI.
- FSM states:
  - `IDLE` → `ACCESS` on a memory op; otherwise stays in `IDLE`.
  - `ACCESS` issues the first access at `address`. On `dmem_resp`:
    - LDI/STI → `INDIRECT`, latching `dmem_rdata` as the pointer.
    - Otherwise → `IDLE`, completing the instruction.
  - `INDIRECT` issues a word read (LDI) or word write (STI) at the latched pointer. On `dmem_resp` → `IDLE`, completing the instruction.
- Word accesses force address bit 0 to 0 and drive `dmem_byte_enable`=2'b11.
- STB lane selection by `address[0]`:
  - `dmem_wdata` = `{store_data[7:0], store_data[7:0]}`.
  - Byte enable is 2'b01 when `address[0]`=0 and 2'b10 when `address[0]`=1.
- LDB: `wb_data` = the byte selected by `address[0]`, sign-extended to 16 bits.
- Loads write `wb_data` from memory. All other instructions write `result`.
- When no request is active, `dmem_address`, `dmem_wdata` and `dmem_byte_enable` are 0.
- `mem_stall` = (`IDLE` and a memory op is present) or (`ACCESS`/`INDIRECT` and not completing this cycle).
- A `dmem_resp` seen in `IDLE` is ignored.
- `valid_in`=0 never issues a request and produces a bubble (`wb_valid`=0).

## Timing
- Reset values: FSM=`IDLE`; `dmem_read`=0, `dmem_write`=0, `dmem_byte_enable`=0, `dmem_address`=0, `dmem_wdata`=0; `wb_valid`=0, `wb_load_regfile`=0, `wb_load_cc`=0, `wb_dr`=0, `wb_data`=0; pointer register=0.
- Non-memory instruction: MEM/WB updates at the next edge, so latency is 1 cycle.
- Load/store latency is 1 + N cycles, where N is the number of cycles until `dmem_resp` in `ACCESS`. The minimum is 2 cycles.
- Indirect instructions add another N' cycles in `INDIRECT`.
- `dmem_read`, `dmem_write`, `dmem_address`, `dmem_byte_enable` and `dmem_wdata` are registered on entry to each access state and held stable until `dmem_resp`.
- In the completing cycle (`dmem_resp` in the final state):
  - `mem_stall` is 0.
  - The MEM/WB register captures at the edge.
  - Upstream advances at that same edge.
- While `mem_stall`=1, each edge loads a bubble into MEM/WB (`wb_valid`=0; `wb_load_regfile`=0; `wb_load_cc`=0).
- At least one `IDLE` cycle separates back-to-back memory ops.
- Asserting `rst_n` low mid-transaction returns everything to reset values immediately. The abandoned instruction is not written back.

## Configuration
- `MEM_ACCESS_INDIRECT_EN` defined: `INDIRECT` state and pointer register are present; LDI/STI perform two accesses.
- Macro undefined: no `INDIRECT` state. LDI/STI take the single-access path as LDR/STR, at `address`, completing from `ACCESS`. In this build the execute stage is responsible for the indirect rewrite.

## Test plan
- ADD (`result`=0x1234, `dr_in`=3, `load_regfile_in`=1), no stall → next cycle `wb_valid`=1, `wb_dr`=3, `wb_data`=0x1234, `mem_stall` never high.
- LDR with `address`=0x3001 and `dmem_resp` after 3 cycles → `dmem_address`=0x3000 and `dmem_read` held 3 cycles; `mem_stall` high 3 cycles; then `wb_data`=`dmem_rdata`.
- LDB with `address`=0x4001 and `dmem_rdata`=0x80FF → `wb_data`=0xFF80.
- STB with `address`=0x4000 and `store_data`=0xABCD → `dmem_write`=1, `dmem_byte_enable`=2'b01, `dmem_wdata`=0xCDCD, `wb_load_regfile`=0.
- STI with `address`=0x5000, pointer read 0x6000 (macro defined) → read at 0x5000, then write at 0x6000 with `dmem_byte_enable`=2'b11. With the macro undefined → a single write at 0x5000.
- `rst_n` low during `ACCESS` with `dmem_read`=1 → `dmem_read`=0 and `wb_valid`=0 immediately. A later `dmem_resp` in `IDLE` has no effect.
